// File: rtl/fpg8_pkg.sv
// Shared constants and state encoding for the shift sequencer and its shifter.
package fpg8_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned STEP_MAX = 3;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

endpackage

// File: rtl/shift_sequencer_if.sv
// Bus between the sequencer and the shared barrel shifter.
interface shift_sequencer_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] from_y;
    logic [DATA_W-1:0] y_shifted;
    logic              left;
    logic              right;
    logic [1:0]        amount;

    modport master (
        output from_y,
        output left,
        output right,
        output amount,
        input  y_shifted
    );

    modport slave (
        input  from_y,
        input  left,
        input  right,
        input  amount,
        output y_shifted
    );
endinterface

// File: rtl/shift_sequencer_shifter.sv
// Shared logical shifter: up to 3 positions per pass, zero fill, pass-through when idle.
module shift_sequencer_shifter (
    shift_sequencer_if.slave bus
);
    always_comb begin
        bus.y_shifted = bus.from_y;
        if (bus.left) begin
            bus.y_shifted = bus.from_y << bus.amount;
        end else if (bus.right) begin
            bus.y_shifted = bus.from_y >> bus.amount;
        end
    end
endmodule

// File: rtl/shift_sequencer.sv
// Multi-pass shift sequencer: splits a 0-15 shift into passes of at most STEP_MAX
// through an external shifter and reports the final value with a one-cycle done.
module shift_sequencer #(
    parameter int unsigned DATA_W   = fpg8_pkg::DATA_W,
    parameter int unsigned STEP_MAX = fpg8_pkg::STEP_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dir_right,
    input  logic [3:0]        amount,
    input  logic [DATA_W-1:0] operand,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] sh_from_Y,
    input  logic [DATA_W-1:0] sh_Y_shifted,
    output logic              sh_left,
    output logic              sh_right,
    output logic [1:0]        sh_amount
);
    import fpg8_pkg::*;

    localparam logic [3:0] StepMax = 4'(STEP_MAX);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] working_q, working_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [3:0]        remaining_q, remaining_d;
    logic              dir_q, dir_d;
    logic [3:0]        step;
    logic [3:0]        rem_next;

    assign step     = (remaining_q > StepMax) ? StepMax : remaining_q;
    assign rem_next = remaining_q - step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            working_q   <= '0;
            result_q    <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            working_q   <= working_d;
            result_q    <= result_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        working_d   = working_q;
        result_d    = result_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        sh_left     = 1'b0;
        sh_right    = 1'b0;
        sh_amount   = 2'd0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    working_d   = operand;
                    remaining_d = amount;
                    dir_d       = dir_right;
                    if (amount == 4'd0) begin
                        state_d  = StDone;
                        result_d = operand;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                sh_left     = ~dir_q;
                sh_right    = dir_q;
                sh_amount   = step[1:0];
                working_d   = sh_Y_shifted;
                remaining_d = rem_next;
                // result is captured on the way into DONE so it is valid with done
                if (rem_next == 4'd0) begin
                    state_d  = StDone;
                    result_d = sh_Y_shifted;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign result    = result_q;
    assign sh_from_Y = working_q;
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter DATA_W, default 16, SHALL set the operand/result width.
REQ-003 Parameter STEP_MAX, default 3, SHALL set the maximum shift per shifter pass, matching the 2-bit shifter amount field.
REQ-004 Ports SHALL be, in order:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- start  in  1  request pulse, sampled in IDLE only
- dir_right  in  1  0 = left shift, 1 = right shift
- amount  in  4  total shift distance, 0-15
- operand  in  DATA_W  value to shift
- busy  out  1  high while a request is in progress
- done  out  1  one-cycle pulse, result valid
- result  out  DATA_W  final shifted value
- sh_from_Y  out  DATA_W  working value to the shifter
- sh_Y_shifted  in  DATA_W  shifter output
- sh_left  out  1  shifter left enable
- sh_right  out  1  shifter right enable
- sh_amount  out  2  shifter amount for the current pass

Function
REQ-005 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-006 In IDLE with start=1, the block SHALL latch operand into the working register, amount into remaining, and dir_right into the direction register.
- amount=0: next state DONE.
- Otherwise: next state SHIFT.
REQ-007 In SHIFT, step SHALL equal min(remaining, STEP_MAX); sh_amount=step; sh_from_Y=working register.
REQ-008 In SHIFT, sh_left SHALL equal ~dir and sh_right SHALL equal dir; outside SHIFT both SHALL be 0.
REQ-009 Each SHIFT cycle SHALL load the working register with sh_Y_shifted and set remaining to remaining-step.
REQ-010 SHIFT SHALL go to DONE when remaining-step==0, and otherwise stay in SHIFT.
REQ-011 Shifts SHALL be logical (zero fill) in both directions; bits shifted out are lost.
REQ-012 In DONE, the block SHALL assert done for exactly one cycle, load result with the working register on entry, and return to IDLE.
REQ-013 result SHALL hold its value until the next DONE.
REQ-014 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-015 Latency SHALL be ceil(amount/STEP_MAX)+1 cycles from the start-sampling edge to done high; amount=0 gives 1 cycle.
REQ-016 start while busy SHALL be ignored, with no queueing.
REQ-017 Changes on operand, amount or dir_right after start is sampled SHALL not affect the operation in progress.
REQ-018 start in the same cycle that done is high SHALL be ignored; the block accepts it on the next IDLE cycle.

Reset
REQ-019 rst_n low SHALL immediately force state=IDLE and clear busy, done, result, working register and remaining to 0.
REQ-020 Reset mid-operation SHALL abandon the operation without producing a done pulse.
REQ-021 After reset release, the first start SHALL be accepted on the first rising edge.

Structure
REQ-022 The shared package fpg8_pkg SHALL hold the state encoding typedef (IDLE/SHIFT/DONE) and the DATA_W and STEP_MAX constants.
REQ-023 The block SHALL drive an external shifter through the sh_* ports so the datapath shifter stays shared.
REQ-024 The testbench SHALL connect the existing shifter module as the natural sub-module.
REQ-025 Step computation SHALL be combinational; all state SHALL be in flops on clk/rst_n.

Verification
REQ-026 Left 0x8001, amount 7 -> three passes with sh_amount 3,3,1; done 4 cycles after start; result=0x0080.
REQ-027 Right 0x8000, amount 15 -> five passes of 3; done after 6 cycles; result=0x0001.
REQ-028 amount=0, operand 0xBEEF -> no pass (sh_left=sh_right=0); done next cycle; result=0xBEEF.
REQ-029 amount=3 left on 0x0001 -> a single pass; result=0x0008; done after 2 cycles.
REQ-030 Second start with operand 0x1234 asserted while busy -> ignored; first result unchanged; busy low after done.
REQ-031 rst_n pulsed low during SHIFT -> immediate IDLE, all outputs 0, no done pulse; a new request then completes normally.
